ege_top: RTL and testbench

EGE_TOP -- requirements
Module: ege_top

---
 rtl/ege_top.sv | 116 +++++++++++
 tb/tb_ege_top.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ege_top.sv
// Exp-Golomb ue(v)/se(v) encoder packing codewords MSB-first into 16-bit words; one-cycle push-to-word latency.
// Accepts an element only if the accumulator can hold a 33-bit codeword; a held word stays frozen until out_ready.
module ege_top #(
    parameter int ACC_W = 64
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_mode,
    input  logic [15:0] in_data,
    input  logic        flush,
    output logic        flush_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic [6:0]  bit_count
);
    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam logic [CNT_W-1:0] C16   = CNT_W'(16);
    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(ACC_W - 33);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t           state, state_nxt;
    logic             done_nxt;
    logic             ready_en;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_ap;
    logic             push, pop;
    logic [16:0]      code_num;
    logic [17:0]      x;
    logic [4:0]       n;
    logic [5:0]       cw_len;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // se mapping uses 17-bit modular arithmetic so that -32768 lands on 65536.
    always_comb begin
        code_num = {1'b0, in_data};
        if (in_mode) begin
            if (!in_data[15] && (in_data != 16'd0))
                code_num = {in_data, 1'b0} - 17'd1;
            else
                code_num = 17'd0 - {in_data, 1'b0};
        end
        x = {1'b0, code_num} + 18'd1;
        n = 5'd0;
        for (int i = 0; i < 18; i++)
            if (x[i]) n = 5'(i);
        cw_len = {n, 1'b0} + 6'd1;
    end

    // Pending bits are left-aligned; everything below the tail is kept zero so
    // the codeword value x can be OR-ed in directly (its leading zeros are implicit).
    always_comb begin
        int sh;
        sh      = 0;
        acc_nxt = pop ? (acc << 16) : acc;
        cnt_ap  = cnt;
        if (pop)
            cnt_ap = (cnt >= C16) ? (cnt - C16) : '0;
        cnt_nxt = cnt_ap;
        if (push) begin
            sh      = ACC_W - int'(cnt_ap) - int'(cw_len);
            acc_nxt = acc_nxt | ({{(ACC_W-18){1'b0}}, x} << sh);
            cnt_nxt = cnt_ap + CNT_W'(cw_len);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state      <= IDLE;
            flush_done <= 1'b0;
            ready_en   <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_done <= done_nxt;
            ready_en   <= 1'b1;
        end
    end

    // No pushes in FLUSH, so a pop of the last <=16 bits empties the accumulator.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE:    if (flush) state_nxt = FLUSH;
            FLUSH:   if ((cnt == '0) || (pop && (cnt <= C16))) begin
                         state_nxt = IDLE;
                         done_nxt  = 1'b1;
                     end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = ready_en && (state == IDLE) && (cnt <= C_MAX);
        out_valid = (cnt >= C16) || ((state == FLUSH) && (cnt != '0));
        out_last  = (state == FLUSH) && (cnt != '0) && (cnt <= C16);
        out_data  = acc[ACC_W-1 -: 16];
        bit_count = 7'(cnt);
    end
endmodule

// File: tb/tb_ege_top.sv
// Directed bench for ege_top: hand-derived Exp-Golomb words, backpressure, flush and reset behaviour.
module tb_ege_top;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_mode;
    logic [15:0] in_data;
    logic        flush, flush_done;
    logic        out_valid, out_ready, out_last;
    logic [15:0] out_data;
    logic [6:0]  bit_count;

    int checks = 0;
    int errors = 0;
    int accepted;

    ege_top #(.ACC_W(64)) dut (
        .wb_clk_i  (clk),
        .wb_rst_n  (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .flush     (flush),
        .flush_done(flush_done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .bit_count (bit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic mode, input logic [15:0] data);
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = data;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_flush(input logic with_push);
        flush    = 1'b1;
        in_valid = with_push;
        in_mode  = 1'b0;
        in_data  = 16'd0;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0;
        flush = 1'b0; out_ready = 1'b1;
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_bit_count", bit_count, 0);
        check("rst_out_data", out_data, 0);
        check("rst_flush_done", flush_done, 0);
        rst_n = 1'b1;
        #1;
        check("rel_ready_before_edge", in_ready, 0);
        tick();
        check("rel_ready_after_edge", in_ready, 1);

        // sixteen ue(0) -> 0xFFFF
        repeat (16) push(1'b0, 16'd0);
        check("ue0x16_valid", out_valid, 1);
        check("ue0x16_data", out_data, 16'hFFFF);
        check("ue0x16_count", bit_count, 16);
        tick();
        check("ue0x16_drained", bit_count, 0);
        check("ue0x16_valid_off", out_valid, 0);

        // ue 1,2,3,4 -> 010 011 00100 00101
        push(1'b0, 16'd1); push(1'b0, 16'd2); push(1'b0, 16'd3); push(1'b0, 16'd4);
        check("ue1234_valid", out_valid, 1);
        check("ue1234_data", out_data, 16'h4C85);
        tick();
        check("ue1234_drained", bit_count, 0);

        // se -1 (011), se +1 (010), flush -> 0x6800
        push(1'b1, 16'hFFFF); push(1'b1, 16'd1);
        check("se_count", bit_count, 6);
        check("se_no_word", out_valid, 0);
        do_flush(1'b0);
        check("se_flush_valid", out_valid, 1);
        check("se_flush_data", out_data, 16'h6800);
        check("se_flush_last", out_last, 1);
        check("se_flush_done_early", flush_done, 0);
        tick();
        check("se_flush_done", flush_done, 1);
        check("se_flush_empty", bit_count, 0);
        tick();
        check("se_flush_done_pulse", flush_done, 0);

        // ue 65535 -> 16 zeros, 1, 16 zeros
        push(1'b0, 16'hFFFF);
        check("ue_max_count", bit_count, 33);
        check("ue_max_w0", out_data, 16'h0000);
        tick();
        check("ue_max_w1", out_data, 16'h8000);
        tick();
        check("ue_max_rem", bit_count, 1);
        check("ue_max_novalid", out_valid, 0);
        do_flush(1'b0);
        check("ue_max_w2", out_data, 16'h0000);
        check("ue_max_last", out_last, 1);
        tick();
        check("ue_max_done", flush_done, 1);
        tick();

        // ready threshold: ue(2) then ue(0) until full at 32 bits
        out_ready = 1'b0;
        push(1'b0, 16'd2);
        accepted = 0;
        in_valid = 1'b1; in_mode = 1'b0; in_data = 16'd0;
        for (int i = 0; i < 35; i++) begin
            if (in_ready) accepted++;
            tick();
        end
        in_valid = 1'b0;
        check("fill_accepted", accepted, 29);
        check("fill_count", bit_count, 32);
        check("fill_ready_low", in_ready, 0);
        check("fill_data", out_data, 16'h7FFF);
        tick(); tick();
        check("fill_data_stable", out_data, 16'h7FFF);
        check("fill_valid_stable", out_valid, 1);
        out_ready = 1'b1;
        tick();
        check("fill_w1", out_data, 16'hFFFF);
        tick();
        check("fill_drained", bit_count, 0);

        // continuous ue(65535) under backpressure: one accepted, then stall
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 1'b0; in_data = 16'hFFFF;
        repeat (3) tick();
        in_valid = 1'b0;
        check("bp_count", bit_count, 33);
        check("bp_ready_low", in_ready, 0);
        check("bp_data", out_data, 16'h0000);
        out_ready = 1'b1;
        tick();
        check("bp_w1", out_data, 16'h8000);
        tick();
        check("bp_rem", bit_count, 1);
        do_flush(1'b0);
        check("bp_last_data", out_data, 16'h0000);
        check("bp_last", out_last, 1);
        tick();
        check("bp_done", flush_done, 1);
        tick();

        // empty flush
        do_flush(1'b0);
        check("eflush_novalid", out_valid, 0);
        check("eflush_not_yet", flush_done, 0);
        tick();
        check("eflush_done", flush_done, 1);
        check("eflush_novalid2", out_valid, 0);
        tick();
        check("eflush_pulse_end", flush_done, 0);

        // flush together with a push: ue(0) included
        do_flush(1'b1);
        check("fp_count", bit_count, 1);
        check("fp_data", out_data, 16'h8000);
        check("fp_last", out_last, 1);
        check("fp_ready_low", in_ready, 0);
        tick();
        check("fp_done", flush_done, 1);
        check("fp_empty", bit_count, 0);
        tick();

        // reset mid-burst
        out_ready = 1'b0;
        push(1'b0, 16'd5); push(1'b0, 16'd7);
        check("mid_count", bit_count, 12);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_count", bit_count, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_last", out_last, 0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check("post_rst_ready", in_ready, 1);
        check("post_rst_valid", out_valid, 0);
        check("post_rst_count", bit_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
